v_piso_tx: RTL and testbench
============================

V_PISO_TX -- requirements
Module: v_piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data word width in bits (minimum 2).
REQ-002 The block SHALL have parameter PARITY_EN, default 1; when 1, one even-parity bit SHALL follow the data bits.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1; when 1, bit WIDTH-1 SHALL be sent first, otherwise bit 0 first.
REQ-004 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 clken  input  1  active-high clock enable; state SHALL advance only on clk edges with clken=1.
REQ-008 din  input  WIDTH  parallel word to transmit.
REQ-009 din_valid  input  1  din holds a word to send.
REQ-010 din_ready  output  1  block can accept a word.
REQ-011 sout  output  1  registered serial data.
REQ-012 sframe  output  1  high while sout carries a frame bit.
REQ-013 done  output  1  one-clk-cycle pulse after the last frame bit.
REQ-014 busy  output  1  high in SHIFT state.

Function
REQ-015 Frame length F SHALL be WIDTH+PARITY_EN bits; the parity bit SHALL be the XOR of all din bits.
REQ-016 The FSM SHALL have two states: IDLE and SHIFT.
REQ-017 In IDLE, din_ready SHALL be 1, busy 0, sframe 0, sout 0.
REQ-018 A word SHALL be accepted on a clk edge with din_valid=1, din_ready=1 and clken=1.
REQ-019 On the accept edge, the block SHALL capture din and parity, enter SHIFT, clear the bit counter, drive the first bit on sout and set sframe=1.
REQ-020 Latency from accept edge to first bit valid on sout SHALL be zero cycles after that edge.
REQ-021 In SHIFT, each clken=1 edge SHALL increment the counter and present the next bit; clken=0 SHALL hold sout, sframe, counter and state.
REQ-022 On the clken=1 edge with counter=F-1, the block SHALL return to IDLE, set sout=0 and sframe=0, and pulse done=1.
REQ-023 done SHALL clear on the next clk edge regardless of clken.
REQ-024 In SHIFT, din_ready SHALL be 0 and din/din_valid SHALL be ignored.
REQ-025 The minimum spacing between consecutive accepts SHALL be F+1 clken cycles.
REQ-026 rst SHALL take priority over clken and handshake.

Reset
REQ-027 On rst=1 at a clk edge, the block SHALL enter IDLE with sout=0, sframe=0, done=0, busy=0, counter=0 and the shift register cleared, regardless of clken.
REQ-028 Reset mid-frame SHALL abort the frame without a done pulse; din_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-029 A shared package/include SHALL hold the state encodings (IDLE=0, SHIFT=1) and the counter width function clog2(F).
REQ-030 One sub-module, v_piso_shifter, SHALL hold the loadable WIDTH+1-bit shift register with synchronous reset, clock enable, load and shift controls.
REQ-031 The FSM, counter, parity and handshake SHALL reside in v_piso_tx.

Verification
REQ-032 With defaults, din=4'b1011 accepted with clken=1 constant: sout SHALL be 1,0,1,1,1 on 5 consecutive cycles, sframe high for 5 cycles, done pulse one cycle after, din_ready=1 again.
REQ-033 With din=4'b0110 and clken toggling 1,0,1,0,...: each bit SHALL be held for 2 clk cycles, sequence 0,1,1,0,0, and done SHALL be 1 for exactly one clk.
REQ-034 With MSB_FIRST=0 and PARITY_EN=0, din=4'b0001: sout SHALL be 1,0,0,0, and done SHALL follow after 4 bits.
REQ-035 When din_valid=1 with din=4'b1111 is applied during the second bit of a frame: it SHALL be ignored, the current frame SHALL complete unchanged, and the word SHALL be accepted only once back in IDLE.
REQ-036 When rst=1 is applied during the third bit with clken=0: the next edge SHALL give sout=0, sframe=0, busy=0, done=0, din_ready=1.
REQ-037 When din_valid=1 with clken=0 in IDLE: no accept SHALL occur, busy SHALL stay 0, and the accept SHALL happen on the first clken=1 edge.

Source files
------------

// File: rtl/v_piso_tx_pkg.sv
// -----------------------------------------------------------------------------
// v_piso_tx_pkg
// Shared definitions for the PISO serial transmitter:
//   - FSM state encodings (IDLE / SHIFT), kept as plain logic constants so the
//     encoding stays visible to legacy tooling and waveform viewers.
//   - clog2() used to size the frame bit counter.
// -----------------------------------------------------------------------------
package v_piso_tx_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Number of bits needed to count 0 .. value-1 (at least 1 bit).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage : v_piso_tx_pkg

// File: rtl/v_piso_tx_if.sv
// -----------------------------------------------------------------------------
// v_piso_tx_if
// Bundles the parallel-word handshake and the serial output of v_piso_tx.
//   din        parallel word to transmit            (master -> slave)
//   din_valid  din holds a word to send              (master -> slave)
//   din_ready  transmitter can accept a word         (slave  -> master)
//   sout       registered serial data                (slave  -> master)
//   sframe     sout carries a frame bit              (slave  -> master)
//   done       one-cycle pulse after last frame bit  (slave  -> master)
//   busy       transmitter is shifting a frame       (slave  -> master)
// -----------------------------------------------------------------------------
interface v_piso_tx_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sframe;
  logic             done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sframe, done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sframe, done, busy
  );

endinterface : v_piso_tx_if

// File: rtl/v_piso_shifter.sv
// -----------------------------------------------------------------------------
// v_piso_shifter
// Loadable WIDTH+1-bit shift register. Zeros are shifted in, so once a frame
// has been fully shifted out the head bit reads 0 without extra clearing.
//   clk    rising-edge clock
//   rst    synchronous active-high reset (clears the register)
//   en     clock enable; load/shift act only when en=1
//   load   load d (has priority over shift)
//   shift  advance by one bit toward the head
//   d      word to load, already arranged in transmit order
//   head   bit currently at the output end of the register
// -----------------------------------------------------------------------------
module v_piso_shifter #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           load,
  input  logic           shift,
  input  logic [WIDTH:0] d,
  output logic           head
);

  logic [WIDTH:0] q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      if (load) begin
        q <= d;
      end else if (shift) begin
        if (MSB_FIRST) q <= {q[WIDTH-1:0], 1'b0};
        else           q <= {1'b0, q[WIDTH:1]};
      end
    end
  end

  assign head = MSB_FIRST ? q[WIDTH] : q[0];

endmodule : v_piso_shifter

// File: rtl/v_piso_tx.sv
// -----------------------------------------------------------------------------
// v_piso_tx
// Parallel-in serial-out transmitter. A word accepted from the handshake is
// sent as WIDTH data bits, optionally followed by one even-parity bit. The
// first bit appears on sout at the accept edge itself; each further clken=1
// edge presents the next bit. The clken=1 edge after the last bit returns to
// IDLE and pulses done for one clk cycle.
//   clk    rising-edge clock
//   rst    synchronous active-high reset, dominates clken and handshake
//   clken  active-high clock enable for all state except done's clearing
//   bus    v_piso_tx_if.slave: din/din_valid/din_ready, sout/sframe/done/busy
// -----------------------------------------------------------------------------
module v_piso_tx
  import v_piso_tx_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clken,
  v_piso_tx_if.slave    bus
);

  localparam int              F    = WIDTH + int'(PARITY_EN);
  localparam int              CW   = clog2(F);
  localparam logic [CW-1:0]   LAST = CW'(F - 1);

  logic [0:0]     state;
  logic [CW-1:0]  cnt;
  logic           done_q;
  logic           par;
  logic [WIDTH:0] frame;
  logic           accept;
  logic           advance;
  logic           head;

  // Even parity: the appended bit makes the total number of ones even.
  assign par = PARITY_EN ? ^bus.din : 1'b0;

  // Arrange the frame so the first bit to send sits at the shifter's head.
  // Without parity the spare position is a 0 pad that is never transmitted.
  assign frame = MSB_FIRST ? {bus.din, par} : {par, bus.din};

  assign accept  = (state == ST_IDLE)  && bus.din_valid && clken;
  assign advance = (state == ST_SHIFT) && clken;

  // The final advance shifts the last bit out too, leaving an all-zero
  // register, which is what drives sout low back in IDLE.
  v_piso_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .en    (clken),
    .load  (accept),
    .shift (advance),
    .d     (frame),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      // done lasts one clk cycle whether or not the next edge is enabled.
      done_q <= 1'b0;
      if (clken) begin
        case (state)
          ST_IDLE: begin
            if (bus.din_valid) begin
              state <= ST_SHIFT;
              cnt   <= '0;
            end
          end
          ST_SHIFT: begin
            if (cnt == LAST) begin
              state  <= ST_IDLE;
              cnt    <= '0;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.din_ready = (state == ST_IDLE);
  assign bus.busy      = (state == ST_SHIFT);
  assign bus.sframe    = (state == ST_SHIFT);
  assign bus.sout      = head;
  assign bus.done      = done_q;

endmodule : v_piso_tx

// File: tb/tb_v_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_v_piso_tx
// Directed bench for v_piso_tx. dut0 uses the defaults (WIDTH=4, parity on,
// MSB first); dut1 sends LSB first without parity. Both share clk, rst and
// clken. Inputs change 1 ns after the rising edge, outputs are sampled there.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_v_piso_tx;

  logic clk = 1'b0;
  logic rst;
  logic clken;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  v_piso_tx_if #(.WIDTH(4)) bus0 ();
  v_piso_tx_if #(.WIDTH(4)) bus1 ();

  v_piso_tx #(.WIDTH(4), .PARITY_EN(1'b1), .MSB_FIRST(1'b1)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .clken (clken),
    .bus   (bus0)
  );

  v_piso_tx #(.WIDTH(4), .PARITY_EN(1'b0), .MSB_FIRST(1'b0)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .clken (clken),
    .bus   (bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks dut0 over a full frame at clken=1, starting just after the accept
  // edge. seq[4] is the first bit expected on sout.
  task automatic frame0(input string tag, input logic [4:0] seq);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s bit%0d", tag, i), bus0.sout, seq[4-i]);
      check($sformatf("%s sframe%0d", tag, i), bus0.sframe, 1'b1);
      check($sformatf("%s ready%0d", tag, i), bus0.din_ready, 1'b0);
      check($sformatf("%s done%0d", tag, i), bus0.done, 1'b0);
      step();
    end
    check({tag, " done"}, bus0.done, 1'b1);
    check({tag, " sout idle"}, bus0.sout, 1'b0);
    check({tag, " sframe idle"}, bus0.sframe, 1'b0);
    check({tag, " ready idle"}, bus0.din_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clken = 1'b0;
    bus0.din = '0; bus0.din_valid = 1'b0;
    bus1.din = '0; bus1.din_valid = 1'b0;
    #1;
    step();
    step();
    // Reset state
    check("rst ready", bus0.din_ready, 1'b1);
    check("rst busy", bus0.busy, 1'b0);
    check("rst sout", bus0.sout, 1'b0);
    check("rst sframe", bus0.sframe, 1'b0);
    check("rst done", bus0.done, 1'b0);
    rst = 1'b0;
    step();

    // 1011 with constant clken: 1,0,1,1 then parity 1
    clken = 1'b1; bus0.din = 4'b1011; bus0.din_valid = 1'b1;
    step();
    bus0.din_valid = 1'b0;
    check("t1 busy", bus0.busy, 1'b1);
    frame0("t1", 5'b10111);
    step();
    check("t1 done clear", bus0.done, 1'b0);

    // 0110 with clken toggling: each bit held two clk cycles
    bus0.din = 4'b0110; bus0.din_valid = 1'b1; clken = 1'b1;
    step();
    bus0.din_valid = 1'b0;
    begin
      logic [4:0] seq;
      seq = 5'b01100;
      for (int i = 0; i < 5; i++) begin
        check($sformatf("t2 bit%0d a", i), bus0.sout, seq[4-i]);
        clken = 1'b0;
        step();
        check($sformatf("t2 bit%0d b", i), bus0.sout, seq[4-i]);
        check($sformatf("t2 sframe%0d", i), bus0.sframe, 1'b1);
        check($sformatf("t2 done%0d", i), bus0.done, 1'b0);
        clken = 1'b1;
        step();
      end
    end
    check("t2 done", bus0.done, 1'b1);
    check("t2 sframe end", bus0.sframe, 1'b0);
    clken = 1'b0;
    step();
    check("t2 done one clk", bus0.done, 1'b0);
    check("t2 ready", bus0.din_ready, 1'b1);
    clken = 1'b1;
    step();

    // LSB first, no parity: 0001 -> 1,0,0,0
    bus1.din = 4'b0001; bus1.din_valid = 1'b1;
    step();
    bus1.din_valid = 1'b0;
    begin
      logic [3:0] seq1;
      seq1 = 4'b1000;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t3 bit%0d", i), bus1.sout, seq1[3-i]);
        check($sformatf("t3 sframe%0d", i), bus1.sframe, 1'b1);
        check($sformatf("t3 done%0d", i), bus1.done, 1'b0);
        step();
      end
    end
    check("t3 done", bus1.done, 1'b1);
    check("t3 sframe end", bus1.sframe, 1'b0);
    check("t3 ready", bus1.din_ready, 1'b1);
    step();

    // Word offered mid-frame is ignored, then accepted back in IDLE
    bus0.din = 4'b1010; bus0.din_valid = 1'b1;
    step();
    bus0.din_valid = 1'b0;
    check("t4 bit0", bus0.sout, 1'b1);
    step();
    bus0.din = 4'b1111; bus0.din_valid = 1'b1;
    check("t4 bit1", bus0.sout, 1'b0);
    check("t4 ready mid", bus0.din_ready, 1'b0);
    step();
    check("t4 bit2", bus0.sout, 1'b1);
    step();
    check("t4 bit3", bus0.sout, 1'b0);
    step();
    check("t4 par", bus0.sout, 1'b0);
    step();
    check("t4 done", bus0.done, 1'b1);
    check("t4 sout idle", bus0.sout, 1'b0);
    step();
    bus0.din_valid = 1'b0;
    check("t4 busy2", bus0.busy, 1'b1);
    frame0("t4b", 5'b11110);
    step();

    // Reset during the third bit with clken=0
    bus0.din = 4'b1011; bus0.din_valid = 1'b1;
    step();
    bus0.din_valid = 1'b0;
    step();
    step();
    check("t5 bit2", bus0.sout, 1'b1);
    clken = 1'b0; rst = 1'b1;
    step();
    check("t5 sout", bus0.sout, 1'b0);
    check("t5 sframe", bus0.sframe, 1'b0);
    check("t5 busy", bus0.busy, 1'b0);
    check("t5 done", bus0.done, 1'b0);
    check("t5 ready", bus0.din_ready, 1'b1);
    rst = 1'b0; clken = 1'b1;
    step();
    check("t5 ready after", bus0.din_ready, 1'b1);
    check("t5 no done", bus0.done, 1'b0);
    check("t5 idle busy", bus0.busy, 1'b0);

    // din_valid with clken=0 in IDLE waits for the first enabled edge
    clken = 1'b0; bus0.din = 4'b0110; bus0.din_valid = 1'b1;
    step();
    check("t6 busy a", bus0.busy, 1'b0);
    step();
    check("t6 busy b", bus0.busy, 1'b0);
    check("t6 ready", bus0.din_ready, 1'b1);
    check("t6 sframe", bus0.sframe, 1'b0);
    clken = 1'b1;
    step();
    bus0.din_valid = 1'b0;
    check("t6 busy c", bus0.busy, 1'b1);
    frame0("t6", 5'b01100);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_v_piso_tx
